// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO bank: per-pad config bit positions and the
// decoded per-pad config record consumed by the pad datapath slices.
package gpio_cfg_pkg;

   localparam int CFG_DIR          = 0;
   localparam int CFG_INV_OUT      = 1;
   localparam int CFG_INV_IN       = 2;
   localparam int MIN_BITS_PER_PAD = 3;

   typedef struct packed {
      logic inv_in;
      logic inv_out;
      logic dir;
   } pad_cfg_t;

   // Position of config bit b of pad p inside the flat chain vector.
   function automatic int pad_bit_idx(input int p, input int bpp, input int b);
      return p * bpp + b;
   endfunction

endpackage

// File: rtl/gpio_bank_ccff_if.sv
// Bundle of the GPIO bank's configuration-chain and pad/core signals.
// The bank uses the slave view; whatever drives it uses the master view.
interface gpio_bank_ccff_if #(
   parameter int NUM_PAD = 4
);
   logic               ccff_head;
   logic               ccff_en;
   logic               ccff_commit;
   logic               ccff_tail;
   logic               config_done;
   logic               commit_err;
   logic [NUM_PAD-1:0] core_out;
   logic [NUM_PAD-1:0] core_in;
   logic [NUM_PAD-1:0] pad_in;
   logic [NUM_PAD-1:0] pad_out;
   logic [NUM_PAD-1:0] pad_oe;

   modport master (
      output ccff_head, ccff_en, ccff_commit, core_out, pad_in,
      input  ccff_tail, config_done, commit_err, core_in, pad_out, pad_oe
   );

   modport slave (
      input  ccff_head, ccff_en, ccff_commit, core_out, pad_in,
      output ccff_tail, config_done, commit_err, core_in, pad_out, pad_oe
   );
endinterface

// File: rtl/gpio_pad_slice.sv
// Combinational datapath of one pad: direction and optional inversion on
// both the drive and receive paths, taken straight from the active config.
module gpio_pad_slice
   import gpio_cfg_pkg::*;
(
   input  pad_cfg_t i_cfg,
   input  logic     i_core_out,
   input  logic     i_pad_in,
   output logic     o_pad_oe,
   output logic     o_pad_out,
   output logic     o_core_in
);

   assign o_pad_oe  = i_cfg.dir;
   assign o_pad_out = i_core_out ^ i_cfg.inv_out;
   // An output pad reports 0 to the fabric rather than echoing its own drive.
   assign o_core_in = i_cfg.dir ? 1'b0 : (i_pad_in ^ i_cfg.inv_in);

endmodule

// File: rtl/gpio_bank_ccff.sv
// Multi-pad GPIO bank with a serial config chain, a bit counter and a
// commit-to-shadow stage so that pads never see a half-loaded config.
module gpio_bank_ccff
   import gpio_cfg_pkg::*;
#(
   parameter int NUM_PAD      = 4,
   parameter int BITS_PER_PAD = 3
) (
   input  logic             prog_clk,
   input  logic             pReset_n,
   gpio_bank_ccff_if.slave  bus
);

   localparam int CHAIN_LEN = NUM_PAD * BITS_PER_PAD;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

   generate
      if (BITS_PER_PAD < MIN_BITS_PER_PAD) begin : g_bad_bpp
         $error("gpio_bank_ccff: BITS_PER_PAD must be at least 3");
      end
   endgenerate

   logic [CHAIN_LEN-1:0] r_sr;
   logic [CHAIN_LEN-1:0] r_active;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_done;
   logic                 r_err;

   logic [CHAIN_LEN-1:0] w_sr_next;
   logic [CHAIN_LEN-1:0] w_active_next;
   logic [CNT_W-1:0]     w_cnt_next;
   logic                 w_err_next;
   logic                 w_commit_ok;

   always_comb begin
      w_commit_ok   = bus.ccff_commit & r_done;
      w_sr_next     = r_sr;
      w_active_next = r_active;
      w_cnt_next    = r_cnt;
      w_err_next    = r_err | (bus.ccff_commit & ~r_done);

      if (bus.ccff_en) begin
         w_sr_next = {r_sr[CHAIN_LEN-2:0], bus.ccff_head};
      end

      // Commit snapshots the pre-shift stage; a same-cycle shift counts as
      // the first bit of the next load.
      if (w_commit_ok) begin
         w_active_next = r_sr;
         w_cnt_next    = bus.ccff_en ? CNT_W'(1) : '0;
      end else if (bus.ccff_en && (r_cnt != CNT_W'(CHAIN_LEN))) begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         r_sr     <= '0;
         r_active <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_sr     <= w_sr_next;
         r_active <= w_active_next;
         r_cnt    <= w_cnt_next;
         r_done   <= (w_cnt_next == CNT_W'(CHAIN_LEN));
         r_err    <= w_err_next;
      end
   end

   assign bus.ccff_tail   = r_sr[CHAIN_LEN-1];
   assign bus.config_done = r_done;
   assign bus.commit_err  = r_err;

   logic [NUM_PAD-1:0] w_pad_oe;
   logic [NUM_PAD-1:0] w_pad_out;
   logic [NUM_PAD-1:0] w_core_in;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PAD; gi++) begin : g_pad
         pad_cfg_t w_cfg;

         assign w_cfg.dir     = r_active[pad_bit_idx(gi, BITS_PER_PAD, CFG_DIR)];
         assign w_cfg.inv_out = r_active[pad_bit_idx(gi, BITS_PER_PAD, CFG_INV_OUT)];
         assign w_cfg.inv_in  = r_active[pad_bit_idx(gi, BITS_PER_PAD, CFG_INV_IN)];

         gpio_pad_slice u_slice (
            .i_cfg      (w_cfg),
            .i_core_out (bus.core_out[gi]),
            .i_pad_in   (bus.pad_in[gi]),
            .o_pad_oe   (w_pad_oe[gi]),
            .o_pad_out  (w_pad_out[gi]),
            .o_core_in  (w_core_in[gi])
         );
      end
   endgenerate

   assign bus.pad_oe  = w_pad_oe;
   assign bus.pad_out = w_pad_out;
   assign bus.core_in = w_core_in;

endmodule

// File: tb/tb_gpio_bank_ccff.sv
// Randomised bench for gpio_bank_ccff against a history-queue reference model.
module tb_gpio_bank_ccff;

   localparam int NP  = 4;
   localparam int BPP = 3;
   localparam int L   = NP * BPP;

   logic clk;
   logic rst_n;

   gpio_bank_ccff_if #(.NUM_PAD(NP)) bus ();

   gpio_bank_ccff #(
      .NUM_PAD      (NP),
      .BITS_PER_PAD (BPP)
   ) dut (
      .prog_clk (clk),
      .pReset_n (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: every bit shifted since reset, newest at the back.
   bit hist[$];
   bit mact[L];
   int mcnt;
   bit mdone;
   bit merr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit sr_bit(input int i);
      if (i < hist.size()) return hist[hist.size() - 1 - i];
      return 1'b0;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < L; i++) mact[i] = 1'b0;
      mcnt  = 0;
      mdone = 1'b0;
      merr  = 1'b0;
   endtask

   task automatic check_all();
      logic [NP-1:0] e_oe, e_out, e_in;
      for (int p = 0; p < NP; p++) begin
         e_oe[p]  = mact[p*BPP + 0];
         e_out[p] = bus.core_out[p] ^ mact[p*BPP + 1];
         e_in[p]  = mact[p*BPP + 0] ? 1'b0 : (bus.pad_in[p] ^ mact[p*BPP + 2]);
      end
      chk("tail",    32'(bus.ccff_tail),   32'(sr_bit(L-1)));
      chk("done",    32'(bus.config_done), 32'(mdone));
      chk("err",     32'(bus.commit_err),  32'(merr));
      chk("pad_oe",  32'(bus.pad_oe),      32'(e_oe));
      chk("pad_out", 32'(bus.pad_out),     32'(e_out));
      chk("core_in", 32'(bus.core_in),     32'(e_in));
   endtask

   task automatic step(input bit head, input bit en, input bit commit);
      bit snap[L];
      @(negedge clk);
      bus.ccff_head   = head;
      bus.ccff_en     = en;
      bus.ccff_commit = commit;
      bus.core_out    = NP'($urandom_range(0, (1 << NP) - 1));
      bus.pad_in      = NP'($urandom_range(0, (1 << NP) - 1));
      @(posedge clk);
      for (int i = 0; i < L; i++) snap[i] = sr_bit(i);
      if (commit && mdone) begin
         mact = snap;
         mcnt = en ? 1 : 0;
      end else begin
         if (commit) merr = 1'b1;
         if (en && mcnt < L) mcnt++;
      end
      if (en) begin
         hist.push_back(head);
         if (hist.size() > L) void'(hist.pop_front());
      end
      mdone = (mcnt == L);
      #1;
      check_all();
   endtask

   task automatic shift_word(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1, 1'b0);
   endtask

   task automatic shift_rand(input int n);
      for (int i = 0; i < n; i++) step(1'($urandom), 1'b1, 1'b0);
   endtask

   // Reset lands mid-cycle to exercise the asynchronous path.
   task automatic do_reset();
      @(negedge clk);
      bus.ccff_en     = 1'b0;
      bus.ccff_commit = 1'b0;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.ccff_head   = 1'b0;
      bus.ccff_en     = 1'b0;
      bus.ccff_commit = 1'b0;
      bus.core_out    = '0;
      bus.pad_in      = 4'b1010;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-shift, then a full fresh load is needed.
      shift_rand(5);
      do_reset();
      shift_rand(L - 1);
      chk("done_before_full", 32'(bus.config_done), 32'd0);
      shift_rand(1);
      chk("done_at_full", 32'(bus.config_done), 32'd1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // Full load: every pad output, no inversion.
      shift_word(32'h249, L);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("full_oe", 32'(bus.pad_oe), 32'hF);
      chk("full_ci", 32'(bus.core_in), 32'h0);

      // Input inversion on pad0 only.
      shift_word(32'h004, L);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.pad_in = 4'b0001;
      #1 chk("inv_ci_hi", 32'(bus.core_in), 32'h0);
      bus.pad_in = 4'b0000;
      #1 chk("inv_ci_lo", 32'(bus.core_in), 32'h1);
      bus.pad_in = 4'b1110;
      #1 chk("inv_ci_pass", 32'(bus.core_in), 32'hF);

      // Early commit is flagged and ignored; later commit still works.
      do_reset();
      shift_rand(7);
      step(1'b0, 1'b0, 1'b1);
      chk("early_err", 32'(bus.commit_err), 32'd1);
      shift_rand(5);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // Shift and commit in the same cycle.
      shift_word(32'($urandom), L);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // Long pass-through with counter saturated.
      shift_rand(2 * L);
      step(1'b0, 1'b0, 1'b0);

      // Random mix of shifts, idles and commits.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
         if (i == 200) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
